// File: rtl/ir_pkg.sv
// Shared types and constants for the IR frame scheduler.
// Optional wait-timeout logic is enabled with IR_SCHED_TIMEOUT_EN.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    W1,
    S2,
    W2,
    GAP
  } state_t;

  localparam int unsigned SEG35_LEN = 35;
  localparam int unsigned SEG32_LEN = 32;

  localparam logic SEG_SEL_FIRST  = 1'b0;
  localparam logic SEG_SEL_SECOND = 1'b1;

endpackage

// File: rtl/ir_rr_arbiter.sv
// Combinational round-robin pick: first set pending bit at or above ptr, with wrap.
module ir_rr_arbiter
  import ir_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [2:0]         ptr,
  output logic [2:0]         grant,
  output logic               valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid && ((pending & (NUM_REQ'(1) << idx)) != '0)) begin
        valid = 1'b1;
        grant = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/ir_frame_scheduler.sv
// Shares one IR encoder between NUM_REQ requesters, sending each frame as a 35-bit then 32-bit segment.
// Define IR_SCHED_TIMEOUT_EN to build the per-segment enc_done timeout and sticky err flag.
module ir_frame_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 40000,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SEG35_LEN-1:0]   data35,
  input  logic [NUM_REQ*SEG32_LEN-1:0]   data32,
  input  logic                           enc_busy,
  input  logic                           enc_done,
  output logic                           seg_start,
  output logic                           seg_sel,
  output logic [SEG35_LEN-1:0]           seg_data,
  output logic [2:0]                     grant_id,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic                           led_out,
  output logic                           err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ir_frame_scheduler: unsupported parameter set");
  end

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    pending_q, pending_d;
  logic [2:0]            rr_q, rr_d;
  logic [31:0]           gap_q, gap_d;
  logic [SEG35_LEN-1:0]  snap35_q, snap35_d, pick35;
  logic [SEG32_LEN-1:0]  snap32_q, snap32_d, pick32;
  logic [2:0]            grant_d, arb_grant;
  logic                  arb_valid;
  logic                  start_d, sel_d;
  logic [SEG35_LEN-1:0]  data_d;
  logic [NUM_REQ-1:0]    ack_d;
  logic                  done_ok;
  logic                  timeout;

  ir_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending (pending_q),
    .ptr     (rr_q),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  // A done pulse coinciding with our own start belongs to an earlier transfer.
  assign done_ok = enc_done && !seg_start;

  always_comb begin
    pick35 = '0;
    pick32 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant == 3'(i)) begin
        pick35 = data35[i*SEG35_LEN +: SEG35_LEN];
        pick32 = data32[i*SEG32_LEN +: SEG32_LEN];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    rr_d      = rr_q;
    gap_d     = gap_q;
    snap35_d  = snap35_q;
    snap32_d  = snap32_q;
    grant_d   = grant_id;
    start_d   = 1'b0;
    sel_d     = seg_sel;
    data_d    = seg_data;
    ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d   = S1;
          grant_d   = arb_grant;
          // A req pulse on the granted bit in this same cycle keeps it pending.
          pending_d = (pending_q & ~(NUM_REQ'(1) << arb_grant)) | req;
          rr_d      = (arb_grant == 3'(NUM_REQ - 1)) ? 3'd0 : arb_grant + 3'd1;
          snap35_d  = pick35;
          snap32_d  = pick32;
        end
      end
      S1: begin
        if (!enc_busy) begin
          start_d = 1'b1;
          sel_d   = SEG_SEL_FIRST;
          data_d  = snap35_q;
          state_d = W1;
        end
      end
      W1: begin
        if (done_ok) begin
          state_d = S2;
        end else if (timeout) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      S2: begin
        if (!enc_busy) begin
          start_d = 1'b1;
          sel_d   = SEG_SEL_SECOND;
          data_d  = {{(SEG35_LEN - SEG32_LEN){1'b0}}, snap32_q};
          state_d = W2;
        end
      end
      W2: begin
        if (done_ok) begin
          state_d = GAP;
          gap_d   = '0;
          ack_d   = NUM_REQ'(1) << grant_id;
        end else if (timeout) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_CYCLES - 1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      gap_q     <= '0;
      snap35_q  <= '0;
      snap32_q  <= '0;
      seg_start <= 1'b0;
      seg_sel   <= 1'b0;
      seg_data  <= '0;
      grant_id  <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      led_out   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      snap35_q  <= snap35_d;
      snap32_q  <= snap32_d;
      seg_start <= start_d;
      seg_sel   <= sel_d;
      seg_data  <= data_d;
      grant_id  <= grant_d;
      ack       <= ack_d;
      busy      <= (state_d != IDLE);
      led_out   <= (state_d == S1) || (state_d == W1) || (state_d == S2) || (state_d == W2);
    end
  end

`ifdef IR_SCHED_TIMEOUT_EN
  logic [31:0] wait_q;

  assign timeout = ((state_q == W1) || (state_q == W2)) && !done_ok &&
                   (wait_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err    <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if ((state_q == W1) || (state_q == W2)) begin
        wait_q <= wait_q + 32'd1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
